// File: rtl/lane_serializer.sv
// Lane serializer: accepts a masked vector of LANES data lanes and emits the
// set lanes one beat at a time, lowest index first, with a drained-vector count.
module lane_serializer #(
    parameter int LANES = 16,
    parameter int DW = 8,
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES-1:0]      in_mask,
    input  logic [LANES*DW-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW-1:0]         out_data,
    output logic [LW-1:0]         out_lane,
    output logic                  out_last,
    output logic [15:0]           vec_cnt
);

    logic [LANES-1:0][DW-1:0] data_reg;
    logic [LANES-1:0]         pending_reg;
    logic [LANES-1:0]         pending_next;
    logic [15:0]              vec_cnt_reg;
    logic [15:0]              vec_cnt_next;
    logic [LANES-1:0]         rest;
    logic [LANES-1:0]         lowest;
    logic                     beat;
    logic                     capture;
    logic [1:0]               cnt_inc;
    logic [LW-1:0]            lane_terms [LANES];
    logic [DW-1:0]            data_terms [LANES];

    // rest drops the lowest set bit; lowest is that bit as a one-hot
    assign rest      = pending_reg & (pending_reg - LANES'(1));
    assign lowest    = pending_reg & ~rest;
    assign out_valid = |pending_reg;
    assign out_last  = out_valid && (rest == '0);
    assign beat      = out_valid && out_ready;
    assign in_ready  = !out_valid || (beat && out_last);
    assign capture   = in_valid && in_ready;
    assign vec_cnt   = vec_cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_terms[gi] = lowest[gi] ? LW'(gi) : '0;
            assign data_terms[gi] = lowest[gi] ? data_reg[gi] : '0;
        end
    endgenerate

    // lowest is one-hot (or zero), so OR-ing the gated terms selects one lane
    always_comb begin
        out_lane = '0;
        out_data = '0;
        for (int i = 0; i < LANES; i++) begin
            out_lane = out_lane | lane_terms[i];
            out_data = out_data | data_terms[i];
        end
    end

    always_comb begin
        pending_next = pending_reg;
        if (beat) begin
            pending_next = rest;
        end
        if (capture) begin
            pending_next = in_mask;
        end
    end

    // a last beat and a zero-mask capture on the same edge both count
    assign cnt_inc      = {1'b0, beat && out_last} + {1'b0, capture && (in_mask == '0)};
    assign vec_cnt_next = vec_cnt_reg + 16'(cnt_inc);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_reg <= '0;
            data_reg    <= '0;
            vec_cnt_reg <= '0;
        end else begin
            pending_reg <= pending_next;
            vec_cnt_reg <= vec_cnt_next;
            if (capture) begin
                data_reg <= in_data;
            end
        end
    end

endmodule
